// File: rtl/ov_7670_capture.sv
// OV7670 RGB565 capture in the PCLK domain: discards settling frames, assembles
// byte pairs into pixels with x/y coordinates, and flags line/frame geometry errors.
module ov_7670_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done_i,
  input  logic        enable_i,
  input  logic        vsync_i,
  input  logic        href_i,
  input  logic [7:0]  d_i,
  output logic [15:0] pixel_o,
  output logic        pixel_valid_o,
  output logic [9:0]  x_o,
  output logic [8:0]  y_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic        line_err_o,
  output logic        frame_err_o,
  output logic        busy_o,
  output logic [1:0]  state_o
);

  // pixel_valid_o is a one-cycle strobe with no backpressure: pixel_o, x_o, y_o
  // and frame_start_o are meaningful only in the cycle where it is high.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SKIP   = 2'd1,
    S_SYNC   = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM    = 10'(V_ACTIVE);
  localparam logic [7:0]  SKIP_LIM = 8'(SKIP_FRAMES);

  state_t      state_q;
  logic        vsync_q;
  logic        href_q;
  logic [7:0]  skip_q;
  logic        phase_q;
  logic [7:0]  hi_q;
  logic [10:0] x_cnt_q;
  logic [9:0]  y_cnt_q;
  logic [15:0] pixel_q;
  logic        pixel_valid_q;
  logic [9:0]  x_out_q;
  logic [8:0]  y_out_q;
  logic        frame_start_q;
  logic        frame_done_q;
  logic        line_err_q;
  logic        frame_err_q;

  logic        vs_rise;
  logic        vs_fall;
  logic        hr_fall;
  logic        byte_en;
  logic        line_end;
  logic        in_range;
  logic        line_bad;
  logic [7:0]  skip_d;
  logic [10:0] x_d;
  logic [9:0]  y_d;
  logic [9:0]  y_end_d;

  always_comb begin
    vs_rise  = vsync_i & ~vsync_q;
    vs_fall  = ~vsync_i & vsync_q;
    hr_fall  = ~href_i & href_q;
    // Bytes presented while VSYNC is high are blanking noise, never pixel data.
    byte_en  = href_i & ~vsync_i;
    line_end = hr_fall & ~vsync_q;
    in_range = (x_cnt_q < H_LIM) && ({1'b0, y_cnt_q} < {1'b0, V_LIM});
    line_bad = phase_q | (x_cnt_q != H_LIM);
    skip_d   = skip_q + 8'd1;
    x_d      = (x_cnt_q == '1) ? x_cnt_q : x_cnt_q + 11'd1;
    y_d      = (y_cnt_q == '1) ? y_cnt_q : y_cnt_q + 10'd1;
    // A line ending on the same edge as the frame still counts toward the frame.
    y_end_d  = line_end ? y_d : y_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      vsync_q       <= 1'b1;
      href_q        <= 1'b0;
      skip_q        <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      x_out_q       <= '0;
      y_out_q       <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      vsync_q       <= vsync_i;
      href_q        <= href_i;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;

      if (!init_done_i) begin
        state_q <= S_IDLE;
        skip_q  <= '0;
        phase_q <= 1'b0;
        x_cnt_q <= '0;
        y_cnt_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (enable_i) begin
              skip_q  <= '0;
              state_q <= (SKIP_FRAMES == 0) ? S_SYNC : S_SKIP;
            end
          end

          S_SKIP: begin
            if (!enable_i) begin
              state_q <= S_IDLE;
            end else if (vs_rise) begin
              skip_q <= skip_d;
              if (skip_d >= SKIP_LIM) state_q <= S_SYNC;
            end
          end

          S_SYNC: begin
            if (!enable_i) begin
              state_q <= S_IDLE;
            end else if (vs_fall) begin
              state_q     <= S_ACTIVE;
              phase_q     <= 1'b0;
              x_cnt_q     <= '0;
              y_cnt_q     <= '0;
              line_err_q  <= 1'b0;
              frame_err_q <= 1'b0;
            end
          end

          S_ACTIVE: begin
            if (byte_en) begin
              if (!phase_q) begin
                hi_q    <= d_i;
                phase_q <= 1'b1;
              end else begin
                phase_q       <= 1'b0;
                x_cnt_q       <= x_d;
                pixel_valid_q <= in_range;
                frame_start_q <= in_range && (x_cnt_q == '0) && (y_cnt_q == '0);
                if (in_range) begin
                  pixel_q <= {hi_q, d_i};
                  x_out_q <= x_cnt_q[9:0];
                  y_out_q <= y_cnt_q[8:0];
                end
                if (x_cnt_q >= H_LIM) line_err_q <= 1'b1;
              end
            end

            if (line_end) begin
              if (line_bad) line_err_q <= 1'b1;
              phase_q <= 1'b0;
              x_cnt_q <= '0;
              y_cnt_q <= y_d;
            end

            if (vs_rise) begin
              frame_done_q <= 1'b1;
              if (y_end_d != V_LIM) frame_err_q <= 1'b1;
              state_q <= enable_i ? S_SYNC : S_IDLE;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign pixel_o       = pixel_q;
  assign pixel_valid_o = pixel_valid_q;
  assign x_o           = x_out_q;
  assign y_o           = y_out_q;
  assign frame_start_o = frame_start_q;
  assign frame_done_o  = frame_done_q;
  assign line_err_o    = line_err_q;
  assign frame_err_o   = frame_err_q;
  assign busy_o        = (state_q != S_IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_ov_7670_capture.sv
// Bench for ov_7670_capture on a small 8x4 geometry: randomized frame traffic,
// frame-level reference model feeding pixel and frame-end expectation queues.
module tb_ov_7670_capture;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int SKIP = 2;
  localparam int RW   = 36;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_done = 1'b0;
  logic        enable = 1'b0;
  logic        vsync = 1'b1;
  logic        href = 1'b0;
  logic [7:0]  d = 8'h00;
  logic [15:0] pixel_o;
  logic        pixel_valid_o;
  logic [9:0]  x_o;
  logic [8:0]  y_o;
  logic        frame_start_o;
  logic        frame_done_o;
  logic        line_err_o;
  logic        frame_err_o;
  logic        busy_o;
  logic [1:0]  state_o;

  // Expected pixel records {frame_start, y, x, pixel} and frame-end {line_err, frame_err}.
  logic [RW-1:0] exp_q[$];
  logic [1:0]    done_q[$];
  logic [RW-1:0] mon_e;
  logic [1:0]    mon_d;

  int tests = 0;
  int fails = 0;

  // Reference model of the capture session at frame granularity.
  bit session   = 1'b0;
  bit cap_now   = 1'b0;
  int skip_left = 0;

  always #5 clk = ~clk;

  ov_7670_capture #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .SKIP_FRAMES(SKIP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init_done_i  (init_done),
    .enable_i     (enable),
    .vsync_i      (vsync),
    .href_i       (href),
    .d_i          (d),
    .pixel_o      (pixel_o),
    .pixel_valid_o(pixel_valid_o),
    .x_o          (x_o),
    .y_o          (y_o),
    .frame_start_o(frame_start_o),
    .frame_done_o (frame_done_o),
    .line_err_o   (line_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [7:0] b);
    vsync = vs;
    href  = hr;
    d     = b;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("outputs in reset", {pixel_o, pixel_valid_o, x_o, y_o, frame_start_o, frame_done_o,
                               line_err_o, frame_err_o, busy_o}, 64'd0);
    check("state in reset", state_o, 64'd0);
  endtask

  task automatic restart();
    init_done = 1'b1;
    enable    = 1'b1;
    session   = 1'b1;
    cap_now   = 1'b0;
    skip_left = SKIP;
    drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int n_lines, input int bad_line, input int bad_bytes,
                            input int en_drop_line, input int init_drop_line,
                            input int reset_line, input bit force_f81f, input bit tight_end);
    logic [7:0] hi;
    logic [7:0] lo;
    int nb;
    bit lerr;
    hi   = 8'h00;
    lerr = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'h00);
    cap_now = session && (skip_left == 0);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < n_lines; l++) begin
      nb = (l == bad_line) ? bad_bytes : 2 * H;
      if (l == en_drop_line) enable = 1'b0;
      if (l == init_drop_line) begin
        init_done = 1'b0;
        session   = 1'b0;
        cap_now   = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        check("busy after init_done drop", busy_o, 64'd0);
      end
      for (int b = 0; b < nb; b++) begin
        if (l == reset_line && b == 1) begin
          reset = 1'b0;
          drive(1'b0, 1'b0, 8'h00);
          check_reset_outputs();
          reset     = 1'b1;
          cap_now   = 1'b0;
          skip_left = SKIP;
          break;
        end
        lo = 8'($urandom_range(0, 255));
        if (force_f81f && l == 0 && b < 2) lo = (b == 0) ? 8'hF8 : 8'h1F;
        if (b % 2 == 0) hi = lo;
        else if (cap_now && l < V && b / 2 < H)
          exp_q.push_back({(l == 0 && b == 1), 9'(l), 10'(b / 2), hi, lo});
        drive(1'b0, 1'b1, lo);
      end
      if (cap_now) lerr |= (nb % 2 != 0) || (nb / 2 != H);
      if (!(tight_end && l == n_lines - 1)) begin
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
        if (cap_now) check("line_err after line", line_err_o, 64'(lerr));
      end
    end
    if (session && cap_now) done_q.push_back({lerr, (n_lines != V)});
    else if (session && skip_left > 0) skip_left--;
    if (en_drop_line >= 0) session = 1'b0;
    drive(1'b1, 1'b0, 8'h00);
    if (en_drop_line >= 0) check("busy after enable drop", busy_o, 64'd0);
  endtask

  always @(negedge clk) begin
    if (pixel_valid_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected pixel_valid: got x=%0d y=%0d pixel=%h, expected none (t=%0t)",
                 x_o, y_o, pixel_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel {fs,y,x,pix}", {frame_start_o, y_o, x_o, pixel_o}, mon_e);
      end
    end else if (frame_start_o) begin
      tests++;
      fails++;
      $display("FAIL frame_start without pixel_valid: got 1 expected 0 (t=%0t)", $time);
    end
    if (frame_done_o) begin
      if (done_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected frame_done: got 1 expected 0 (t=%0t)", $time);
      end else begin
        mon_d = done_q.pop_front();
        check("frame_done {line_err,frame_err}", {line_err_o, frame_err_o}, mon_d);
      end
    end
  end

  initial begin
    #2000000;
    tests++;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
    check("idle without init_done", busy_o, 64'd0);

    // Settling frames, then a captured frame starting with 0xF81F.
    restart();
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, -1, -1, 1'b1, 1'b0);
    check("busy while capturing", busy_o, 64'd1);

    // Geometry errors and their clearing on the next frame.
    send_frame(V, 1, 2 * H - 1, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V - 1, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, 2, 2 * H + 4, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b1);

    // Enable dropped mid-frame: frame completes, then idle.
    send_frame(V, -1, 0, 2, -1, -1, 1'b0, 1'b0);

    // init_done dropped mid-frame: immediate idle, no frame_done.
    restart();
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, 2, -1, 1'b0, 1'b0);

    // Reset between high and low byte: settling restarts.
    restart();
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, -1, 1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b0);
    send_frame(V, -1, 0, -1, -1, -1, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h00);
    check("pixels still expected", exp_q.size(), 64'd0);
    check("frame_done still expected", done_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ov_7670_capture.md
OV_7670_CAPTURE -- requirements
Module: ov_7670_capture

Interface
REQ-001 Parameter H_ACTIVE, 640, pixels per line expected.
REQ-002 Parameter V_ACTIVE, 480, lines per frame expected.
REQ-003 Parameter SKIP_FRAMES, 2, whole frames discarded after capture begins (sensor settling).
REQ-004 clk  in  1  camera PCLK; all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 init_done  in  1  camera register initialization complete, level, clk-synchronous.
REQ-007 enable  in  1  capture request, level.
REQ-008 vsync  in  1  camera VSYNC, high during vertical blanking.
REQ-009 href  in  1  camera HREF, high during active line bytes.
REQ-010 d  in  8  camera data byte, RGB565, high byte first.
REQ-011 pixel  out  16  assembled RGB565 pixel {first byte, second byte}.
REQ-012 pixel_valid  out  1  one-cycle strobe, pixel/x/y valid.
REQ-013 x  out  10  column of current pixel, 0..H_ACTIVE-1.
REQ-014 y  out  9  row of current pixel, 0..V_ACTIVE-1.
REQ-015 frame_start  out  1  one-cycle strobe, first pixel of a captured frame.
REQ-016 frame_done  out  1  one-cycle strobe, captured frame ended.
REQ-017 line_err  out  1  sticky: line byte count odd or pixel count != H_ACTIVE.
REQ-018 frame_err  out  1  sticky: line count != V_ACTIVE at frame end.
REQ-019 busy  out  1  high in any state except S_IDLE.

Function
REQ-020 States: S_IDLE, S_SKIP, S_SYNC, S_ACTIVE; 2-bit encoding, unused encodings SHALL go to S_IDLE.
REQ-021 vsync_q (reset 1) and href_q (reset 0) hold previous-cycle values; vs_rise = vsync & ~vsync_q, vs_fall = ~vsync & vsync_q, hr_fall = ~href & href_q.
REQ-022 S_IDLE -> S_SKIP when init_done & enable; skip counter cleared; if SKIP_FRAMES = 0, go directly to S_SYNC.
REQ-023 S_SKIP: counter increments on each vs_rise; reaching SKIP_FRAMES -> S_SYNC; no pixel_valid output.
REQ-024 S_SYNC: on vs_fall -> S_ACTIVE, x/y/byte phase cleared, line_err/frame_err cleared.
REQ-025 S_ACTIVE: each cycle with href=1 samples d; phase 0 stores high byte, phase 1 forms pixel.
REQ-026 pixel, pixel_valid, x, y registered on the edge sampling the low byte; valid for the following cycle only (latency 1 from low-byte edge).
REQ-027 x increments after each pixel; on hr_fall: if phase=1 or x != H_ACTIVE then line_err<=1; x<=0, phase<=0, y increments.
REQ-028 Pixels with x >= H_ACTIVE or y >= V_ACTIVE SHALL NOT assert pixel_valid; line_err set for x overflow; x and y counters SHALL saturate, not wrap.
REQ-029 frame_start SHALL coincide with the pixel_valid of x=0, y=0 of each captured frame.
REQ-030 S_ACTIVE on vs_rise: frame_done=1 for one cycle; frame_err<=1 if line count != V_ACTIVE; -> S_SYNC if enable else S_IDLE.
REQ-031 enable deasserted mid-frame: current frame completes normally, then S_IDLE.
REQ-032 init_done deasserted in any state: next state S_IDLE immediately, pixel_valid 0, no frame_done, counters cleared.
REQ-033 vs_rise and hr_fall in same cycle: line accounting (REQ-027) applied before frame check.
REQ-034 href high while vsync high in S_ACTIVE: bytes ignored.
REQ-035 line_err/frame_err hold until next S_SYNC -> S_ACTIVE transition or reset.

Reset
REQ-036 reset=0 SHALL force S_IDLE; pixel=0, pixel_valid=0, x=0, y=0, frame_start=0, frame_done=0, line_err=0, frame_err=0, busy=0; all counters 0.
REQ-037 reset mid-line SHALL discard partial pixel; no strobe after release until a new vs_fall in S_SYNC.

Verification
REQ-038 init_done=1, enable=1, SKIP_FRAMES=2, three 640x480 frames -> pixel_valid only in third frame; 307200 strobes; one frame_start, one frame_done; no errors.
REQ-039 bytes 0xF8,0x1F at x=0,y=0 -> pixel=0xF81F, x=0, y=0, frame_start=1, cycle after low-byte edge.
REQ-040 line with 1279 bytes -> line_err=1 at hr_fall, persists to frame end; clears at next vs_fall.
REQ-041 frame with 479 lines -> frame_done=1, frame_err=1; line with 642 pixels -> 640 valid, line_err=1.
REQ-042 enable dropped at y=100 -> frame completes to y=479, frame_done, then busy=0; init_done dropped at y=100 -> busy=0 next cycle, no frame_done.
REQ-043 reset asserted between high and low byte -> all outputs 0; after release no pixel_valid until vs_fall following skip completion.
